jt49_mavg_dc: RTL and testbench



---
 rtl/jt49_mavg_dc_if.sv | 13 +
 rtl/jt49_mavg_dc.sv | 53 +++++
 tb/tb_jt49_mavg_dc.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/jt49_mavg_dc_if.sv
// Sample-stream bundle between the upstream delay-line stage and the
// moving-average DC-removal stage.
interface jt49_mavg_dc_if #(parameter int dw = 8);
   logic          cen;
   logic [dw-1:0] din;
   logic [dw-1:0] dly;
   logic [dw-1:0] avg;
   logic [dw:0]   dcout;
   logic          valid;

   modport master (output cen, din, dly, input avg, dcout, valid);
   modport slave  (input cen, din, dly, output avg, dcout, valid);
endinterface

// File: rtl/jt49_mavg_dc.sv
// Moving-average DC removal: running sum over the last 2**depth enabled
// samples, with the window average subtracted from the (one-tick delayed) input.
module jt49_mavg_dc #(
   parameter int dw    = 8,
   parameter int depth = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   jt49_mavg_dc_if.slave  bus
);

   logic [dw+depth-1:0] r_acc;
   logic [dw-1:0]       r_din;
   logic [depth:0]      r_cnt;
   logic [dw-1:0]       r_avg;
   logic [dw:0]         r_dcout;
   logic                r_valid;

   logic                w_full;
   logic [dw-1:0]       w_sub;
   logic [dw-1:0]       w_accTop;

   // Delay-line RAM is undefined after reset, so its output is ignored until
   // the window has been filled once.
   assign w_full   = r_cnt[depth];
   assign w_sub    = w_full ? bus.dly : '0;
   assign w_accTop = r_acc[dw+depth-1:depth];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc   <= '0;
         r_din   <= '0;
         r_cnt   <= '0;
         r_avg   <= '0;
         r_dcout <= '0;
         r_valid <= 1'b0;
      end else if (bus.cen) begin
         r_acc   <= r_acc + {{depth{1'b0}}, bus.din} - {{depth{1'b0}}, w_sub};
         r_din   <= bus.din;
         if (!w_full) begin
            r_cnt <= r_cnt + {{depth{1'b0}}, 1'b1};
         end
         r_avg   <= w_accTop;
         r_dcout <= {1'b0, r_din} - {1'b0, w_accTop};
         r_valid <= w_full;
      end
   end

   assign bus.avg   = r_avg;
   assign bus.dcout = r_dcout;
   assign bus.valid = r_valid;

endmodule

// File: tb/tb_jt49_mavg_dc.sv
// Self-checking bench for jt49_mavg_dc (dw=8, depth=2): vector table, window-sum
// reference model, and hand-written reset / clock-enable / full-scale sequences.
module tb_jt49_mavg_dc;

   localparam int DW    = 8;
   localparam int DEPTH = 2;
   localparam int WIN   = 1 << DEPTH;

   typedef struct {
      logic [7:0] din;
      logic [7:0] expAvg;
      logic [8:0] expDc;
      logic       expValid;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [7:0] samp[$];
   logic [7:0] garbage;
   vec_t vecs[15];

   jt49_mavg_dc_if #(.dw(DW)) bus ();

   jt49_mavg_dc #(.dw(DW), .depth(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: avg after n ticks is the window sum of samples n-5..n-2 over 2**depth,
   // dcout is the sample from tick n-2 minus that average.
   task automatic checkModel(input string tag);
      int          n;
      int          sum;
      logic [7:0]  eAvg;
      logic [7:0]  dinR;
      logic [8:0]  eDc;
      n   = samp.size();
      sum = 0;
      for (int i = (n - WIN - 1 < 0 ? 0 : n - WIN - 1); i <= n - 2; i++) sum += samp[i];
      eAvg = 8'((sum % (256 * WIN)) / WIN);
      dinR = (n >= 2) ? samp[n-2] : 8'd0;
      eDc  = {1'b0, dinR} - {1'b0, eAvg};
      checkOutput($sformatf("%s_avg_n%0d", tag, n), {1'b0, bus.avg}, {1'b0, eAvg});
      checkOutput($sformatf("%s_dc_n%0d", tag, n), bus.dcout, eDc);
      checkOutput($sformatf("%s_valid_n%0d", tag, n), {8'd0, bus.valid}, {8'd0, n >= WIN + 1});
   endtask

   task automatic applyStimulus(input logic en, input logic [7:0] d);
      @(negedge clk);
      bus.cen = en;
      bus.din = d;
      if (!en)                    bus.dly = 8'($urandom_range(255));
      else if (samp.size() >= WIN) bus.dly = samp[samp.size() - WIN];
      else                         bus.dly = garbage;
      @(posedge clk);
      #1;
      if (en) samp.push_back(d);
   endtask

   task automatic resetDut();
      bus.cen = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      samp.delete();
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      garbage = 8'hFF;
      rst_n   = 1'b0;
      bus.cen = 1'b0;
      bus.din = '0;
      bus.dly = '0;

      vecs[0]  = '{8'd100, 8'd0,   9'h000, 1'b0};
      vecs[1]  = '{8'd100, 8'd25,  9'h04B, 1'b0};
      vecs[2]  = '{8'd100, 8'd50,  9'h032, 1'b0};
      vecs[3]  = '{8'd100, 8'd75,  9'h019, 1'b0};
      vecs[4]  = '{8'd100, 8'd100, 9'h000, 1'b1};
      for (int i = 5; i < 10; i++) vecs[i] = '{8'd100, 8'd100, 9'h000, 1'b1};
      vecs[10] = '{8'd20,  8'd100, 9'h000, 1'b1};
      vecs[11] = '{8'd20,  8'd80,  9'h1C4, 1'b1};
      vecs[12] = '{8'd20,  8'd60,  9'h1D8, 1'b1};
      vecs[13] = '{8'd20,  8'd40,  9'h1EC, 1'b1};
      vecs[14] = '{8'd20,  8'd20,  9'h000, 1'b1};

      #12;
      checkOutput("reset_avg", {1'b0, bus.avg}, 9'd0);
      checkOutput("reset_dc", bus.dcout, 9'd0);
      checkOutput("reset_valid", {8'd0, bus.valid}, 9'd0);
      resetDut();

      // Constant 100 then a step to 20, with 0xFF on dly through warm-up.
      for (int i = 0; i < 15; i++) begin
         applyStimulus(1'b1, vecs[i].din);
         checkOutput($sformatf("vec%0d_avg", i), {1'b0, bus.avg}, {1'b0, vecs[i].expAvg});
         checkOutput($sformatf("vec%0d_dc", i), bus.dcout, vecs[i].expDc);
         checkOutput($sformatf("vec%0d_valid", i), {8'd0, bus.valid}, {8'd0, vecs[i].expValid});
         checkModel("vecmodel");
      end

      // Asynchronous reset between edges after 7 random ticks.
      resetDut();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 8'($urandom_range(255)));
         checkModel("pre_rst");
      end
      bus.cen = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_avg", {1'b0, bus.avg}, 9'd0);
      checkOutput("async_rst_dc", bus.dcout, 9'd0);
      checkOutput("async_rst_valid", {8'd0, bus.valid}, 9'd0);
      @(negedge clk);
      rst_n = 1'b1;
      samp.delete();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 8'($urandom_range(255)));
         checkModel("post_rst");
      end

      // Clock enable 1-in-3 with random data and random dly on idle cycles.
      garbage = 8'($urandom_range(255));
      resetDut();
      for (int i = 0; i < 60; i++) begin
         applyStimulus(i % 3 == 0, 8'($urandom_range(255)));
         checkModel("cen3");
      end

      // Full scale, then alternating 0/255.
      resetDut();
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'd255);
      checkOutput("fs_avg", {1'b0, bus.avg}, 9'd255);
      checkOutput("fs_dc", bus.dcout, 9'd0);
      checkModel("fs");
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, (i % 2 == 0) ? 8'd0 : 8'd255);
      checkOutput("alt_avg_a", {1'b0, bus.avg}, 9'd127);
      checkOutput("alt_dc_a", bus.dcout, 9'h181);
      applyStimulus(1'b1, 8'd0);
      checkOutput("alt_avg_b", {1'b0, bus.avg}, 9'd127);
      checkOutput("alt_dc_b", bus.dcout, 9'h080);
      checkModel("alt");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
